instr_fetch: RTL and testbench

Instruction fetch unit feeding the decode controller. Issues sequential reads to a synchronous instruction memory, buffers returned words in a small prefetch FIFO, and presents them as `instr`/`valid`, advancing on `next_instr`. On `jump` it reloads the PC from `jdata`, discards all buffered and in-flight words, and pulses `exe_flush` for one cycle.

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit for the decode controller. It issues sequential reads
// to a synchronous instruction memory, buffers the returned words in a small
// prefetch FIFO and presents the head word as o_instr/o_valid. The head word
// advances whenever the consumer asserts i_next_instr. A jump reloads the PC,
// throws away every buffered and in-flight word, and raises o_exe_flush for
// the following cycle.
//
// Parameters
//   WIDTH_INSTR  instruction word width
//   WIDTH_JDATA  PC / jump target width (instruction-word addressed)
//   FIFO_DEPTH   prefetch entries, power of 2, >= 2
//   RESET_PC     PC value after reset
//
// Ports
//   i_clk         clock, all state on rising edge
//   i_rst_n       synchronous active-low reset
//   i_run         fetch enable; 0 stops new reads, buffered words still drain
//   o_imem_rd     read strobe to instruction memory
//   o_imem_addr   read address (current PC)
//   i_imem_rdata  read data, valid the cycle after o_imem_rd
//   o_instr       FIFO head word (show-ahead)
//   o_valid       o_instr holds a live instruction
//   i_next_instr  consumer accepts the head word this cycle
//   i_jump        redirect request this cycle
//   i_jdata       jump target, sampled when i_jump=1
//   o_exe_flush   one-cycle squash pulse following a jump
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned WIDTH_INSTR = 16,
  parameter int unsigned WIDTH_JDATA = 24,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [WIDTH_JDATA-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_run,
  output logic                   o_imem_rd,
  output logic [WIDTH_JDATA-1:0] o_imem_addr,
  input  logic [WIDTH_INSTR-1:0] i_imem_rdata,
  output logic [WIDTH_INSTR-1:0] o_instr,
  output logic                   o_valid,
  input  logic                   i_next_instr,
  input  logic                   i_jump,
  input  logic [WIDTH_JDATA-1:0] i_jdata,
  output logic                   o_exe_flush
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [WIDTH_JDATA-1:0] r_pc;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic                   r_inflight;
  logic                   r_discard;
  logic                   r_exe_flush;
  logic [WIDTH_INSTR-1:0] r_fifo [FIFO_DEPTH];

  logic                   w_valid;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_issue;
  logic [CW:0]            w_occupancy;

  // Credit check counts the word still in flight as already occupying a slot,
  // so the return of an issued read can never find the FIFO full. A pop in the
  // same cycle frees a slot early, which keeps the stream at one word per cycle
  // even with a two-entry FIFO.
  always_comb begin
    w_valid     = (r_count != '0);
    w_pop       = i_next_instr & w_valid & ~i_jump;
    w_push      = r_inflight & ~r_discard & ~i_jump;
    w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    w_issue     = i_rst_n & i_run & ~i_jump & (w_occupancy < (CW+1)'(FIFO_DEPTH));
  end

  assign o_imem_rd   = w_issue;
  assign o_imem_addr = r_pc;
  assign o_valid     = i_rst_n & w_valid;
  assign o_instr     = r_fifo[r_rd_ptr];
  assign o_exe_flush = r_exe_flush;

  // Control state. A jump beats everything else: the FIFO is emptied and the
  // memory return arriving in the jump cycle is simply not pushed. No read is
  // issued during the jump cycle, so nothing stale can arrive afterwards and
  // the discard flag never needs to be raised.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_inflight  <= 1'b0;
      r_discard   <= 1'b0;
      r_exe_flush <= 1'b0;
    end else begin
      r_exe_flush <= i_jump;
      r_discard   <= 1'b0;
      if (i_jump) begin
        r_pc       <= i_jdata;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc <= r_pc + WIDTH_JDATA'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage array needs no reset; r_count alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      r_fifo[r_wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. Memory model returns mem[A] = A[15:0] one
// cycle after a read. The main instance is driven from a per-cycle vector
// table; a second instance with RESET_PC = 0xFFFFFE covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rstN;
  logic        run;
  logic        nextInstr;
  logic        jump;
  logic [23:0] jdata;
  logic        imemRd;
  logic [23:0] imemAddr;
  logic [15:0] imemRdata;
  logic [15:0] instr;
  logic        valid;
  logic        exeFlush;

  logic        rst1N;
  logic        imemRd1;
  logic [23:0] imemAddr1;
  logic [15:0] imemRdata1;
  logic [15:0] instr1;
  logic        valid1;
  logic        exeFlush1;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  instr_fetch #(.WIDTH_INSTR(16), .WIDTH_JDATA(24), .FIFO_DEPTH(4), .RESET_PC(24'h000000)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_run(run),
    .o_imem_rd(imemRd), .o_imem_addr(imemAddr), .i_imem_rdata(imemRdata),
    .o_instr(instr), .o_valid(valid), .i_next_instr(nextInstr),
    .i_jump(jump), .i_jdata(jdata), .o_exe_flush(exeFlush)
  );

  instr_fetch #(.WIDTH_INSTR(16), .WIDTH_JDATA(24), .FIFO_DEPTH(4), .RESET_PC(24'hFFFFFE)) dutWrap (
    .i_clk(clk), .i_rst_n(rst1N), .i_run(1'b1),
    .o_imem_rd(imemRd1), .o_imem_addr(imemAddr1), .i_imem_rdata(imemRdata1),
    .o_instr(instr1), .o_valid(valid1), .i_next_instr(1'b1),
    .i_jump(1'b0), .i_jdata(24'h000000), .o_exe_flush(exeFlush1)
  );

  // Synchronous instruction memories: word at address A is A[15:0].
  always @(posedge clk) begin
    if (imemRd) imemRdata <= imemAddr[15:0];
    if (imemRd1) imemRdata1 <= imemAddr1[15:0];
  end

  typedef struct packed {
    logic        rstN;
    logic        run;
    logic        nextInstr;
    logic        jump;
    logic [23:0] jdata;
    logic        expRd;
    logic        chkAddr;
    logic [23:0] expAddr;
    logic        expValid;
    logic        chkInstr;
    logic [15:0] expInstr;
    logic        expFlush;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rn, input logic r, input logic n, input logic j,
                              input logic [23:0] jd, input logic rd, input logic ca,
                              input logic [23:0] a, input logic v, input logic ci,
                              input logic [15:0] ins, input logic f);
    vec_t t;
    t.rstN = rn; t.run = r; t.nextInstr = n; t.jump = j; t.jdata = jd;
    t.expRd = rd; t.chkAddr = ca; t.expAddr = a; t.expValid = v;
    t.chkInstr = ci; t.expInstr = ins; t.expFlush = f;
    return t;
  endfunction

  // One field comparison; every call steps the miscompare count on failure.
  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstN      = v.rstN;
    run       = v.run;
    nextInstr = v.nextInstr;
    jump      = v.jump;
    jdata     = v.jdata;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    nVectors++;
    checkEq($sformatf("v%0d imem_rd", idx), {31'b0, imemRd}, {31'b0, v.expRd});
    checkEq($sformatf("v%0d valid", idx), {31'b0, valid}, {31'b0, v.expValid});
    checkEq($sformatf("v%0d exe_flush", idx), {31'b0, exeFlush}, {31'b0, v.expFlush});
    if (v.chkAddr) checkEq($sformatf("v%0d imem_addr", idx), {8'b0, imemAddr}, {8'b0, v.expAddr});
    if (v.chkInstr) checkEq($sformatf("v%0d instr", idx), {16'b0, instr}, {16'b0, v.expInstr});
  endtask

  initial begin
    //                rn r  n  j  jdata       rd ca addr        v  ci instr     f
    vecs[0]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000000, 0, 0, 16'h0000, 0);
    vecs[1]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000001, 0, 0, 16'h0000, 0);
    vecs[2]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000002, 1, 1, 16'h0000, 0);
    vecs[3]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000003, 1, 1, 16'h0001, 0);
    vecs[4]  = mk(1, 1, 1, 1, 24'h100,   0, 1, 24'h000004, 1, 1, 16'h0002, 0);
    vecs[5]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000100, 0, 0, 16'h0000, 1);
    vecs[6]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000101, 0, 0, 16'h0000, 0);
    vecs[7]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000102, 1, 1, 16'h0100, 0);
    vecs[8]  = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000103, 1, 1, 16'h0101, 0);
    vecs[9]  = mk(1, 1, 1, 1, 24'h10,    0, 1, 24'h000104, 1, 1, 16'h0102, 0);
    vecs[10] = mk(1, 1, 1, 1, 24'h20,    0, 1, 24'h000010, 0, 0, 16'h0000, 1);
    vecs[11] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000020, 0, 0, 16'h0000, 1);
    vecs[12] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000021, 0, 0, 16'h0000, 0);
    vecs[13] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000022, 1, 1, 16'h0020, 0);
    vecs[14] = mk(1, 1, 0, 0, 24'h0,     1, 1, 24'h000023, 1, 1, 16'h0021, 0);
    vecs[15] = mk(1, 1, 0, 0, 24'h0,     1, 1, 24'h000024, 1, 1, 16'h0021, 0);
    vecs[16] = mk(1, 1, 0, 0, 24'h0,     0, 1, 24'h000025, 1, 1, 16'h0021, 0);
    vecs[17] = mk(1, 1, 0, 0, 24'h0,     0, 1, 24'h000025, 1, 1, 16'h0021, 0);
    vecs[18] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000025, 1, 1, 16'h0021, 0);
    vecs[19] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000026, 1, 1, 16'h0022, 0);
    vecs[20] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000027, 1, 1, 16'h0023, 0);
    vecs[21] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000028, 1, 1, 16'h0024, 0);
    vecs[22] = mk(1, 0, 1, 0, 24'h0,     0, 1, 24'h000029, 1, 1, 16'h0025, 0);
    vecs[23] = mk(1, 0, 1, 0, 24'h0,     0, 1, 24'h000029, 1, 1, 16'h0026, 0);
    vecs[24] = mk(1, 0, 1, 0, 24'h0,     0, 1, 24'h000029, 1, 1, 16'h0027, 0);
    vecs[25] = mk(1, 0, 1, 0, 24'h0,     0, 1, 24'h000029, 1, 1, 16'h0028, 0);
    vecs[26] = mk(1, 0, 1, 0, 24'h0,     0, 1, 24'h000029, 0, 0, 16'h0000, 0);
    vecs[27] = mk(1, 0, 1, 0, 24'h0,     0, 1, 24'h000029, 0, 0, 16'h0000, 0);
    vecs[28] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000029, 0, 0, 16'h0000, 0);
    vecs[29] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h00002A, 0, 0, 16'h0000, 0);
    vecs[30] = mk(0, 1, 1, 0, 24'h0,     0, 0, 24'h000000, 0, 0, 16'h0000, 0);
    vecs[31] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000000, 0, 0, 16'h0000, 0);
    vecs[32] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000001, 0, 0, 16'h0000, 0);
    vecs[33] = mk(1, 1, 1, 0, 24'h0,     1, 1, 24'h000002, 1, 1, 16'h0000, 0);

    // Cold reset of both instances; the wrap instance stays in reset until
    // its own sequence at the end.
    rstN = 1'b0; rst1N = 1'b0; run = 1'b0; nextInstr = 1'b0; jump = 1'b0; jdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    nVectors++;
    checkEq("reset valid", {31'b0, valid}, 32'd0);
    checkEq("reset imem_rd", {31'b0, imemRd}, 32'd0);
    checkEq("reset exe_flush", {31'b0, exeFlush}, 32'd0);
    checkEq("reset imem_addr", {8'b0, imemAddr}, 32'd0);
    @(posedge clk); #1;

    // Table: each vector is one cycle, outputs sampled at the falling edge.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      @(posedge clk); #1;
    end

    // PC wrap: addresses FFFFFE, FFFFFF, 000000 ... and matching words.
    rst1N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [23:0] expA;
      logic [15:0] expW;
      expA = 24'hFFFFFE + 24'(k);
      expW = 16'hFFFE + 16'(k - 2);
      @(negedge clk);
      nVectors++;
      checkEq($sformatf("wrap%0d imem_addr", k), {8'b0, imemAddr1}, {8'b0, expA});
      checkEq($sformatf("wrap%0d imem_rd", k), {31'b0, imemRd1}, 32'd1);
      checkEq($sformatf("wrap%0d valid", k), {31'b0, valid1}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) checkEq($sformatf("wrap%0d instr", k), {16'b0, instr1}, {16'b0, expW});
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
